// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: opcode, format codes and helpers shared by the immediate decode stage.
package imm_decode_stage_pkg;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// imm_extract: combinational immediate/format decode of one RISC-V instruction word.
module imm_extract
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_ZIMM  = 1,
    parameter int EN_SHAMT = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] i_w, s_w, b_w, u_w, j_w;
    logic [5:0]  sh;
    logic        is_shift, is_zimm;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign i_w = {{20{instr[31]}}, instr[31:20]};
    assign s_w = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_w = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_w = {instr[31:12], 12'b0};
    assign j_w = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    // RV64 shifts carry a 6-bit shamt, RV32 only 5
    assign sh       = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    assign is_shift = (EN_SHAMT != 0) && (f3[1:0] == 2'b01);
    assign is_zimm  = (EN_ZIMM != 0) && f3[2];

    always_comb begin
        illegal = 1'b0;
        fmt     = FMT_I;
        imm     = XLEN'(sext32(i_w));
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(sext32(u_w));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'(sext32(j_w));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(sext32(b_w));
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'(sext32(s_w));
            end
            OPC_OPIMM: imm = is_shift ? XLEN'(sh) : imm;
            OPC_SYSTEM: begin
                fmt = is_zimm ? FMT_Z : FMT_I;
                imm = is_zimm ? XLEN'(instr[19:15]) : imm;
            end
            OPC_LOAD, OPC_MISC_MEM, OPC_OPIMM32, OPC_JALR: fmt = FMT_I;
            OPC_OP, OPC_OP32: begin
                fmt = FMT_NONE;
                imm = '0;
            end
            default: begin
                fmt     = FMT_NONE;
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: immediate/target decode behind a 2-entry skid buffer.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_ZIMM  = 1,
    parameter int EN_SHAMT = 1
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInstrucao,
    input  logic [XLEN-1:0] iPC,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oImm,
    output logic [XLEN-1:0] oTarget,
    output logic [2:0]      oFmt,
    output logic            oIllegal
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_fmt;
    logic            ext_ill;
    entry_t          new_e, head, skid;
    logic [1:0]      state, nxt;
    logic            in_fire, out_fire, load_head, load_skid;

    imm_extract #(.XLEN(XLEN), .EN_ZIMM(EN_ZIMM), .EN_SHAMT(EN_SHAMT)) u_extract (
        .instr   (iInstrucao),
        .imm     (ext_imm),
        .fmt     (ext_fmt),
        .illegal (ext_ill)
    );

    assign new_e    = '{imm: ext_imm, target: iPC + ext_imm, fmt: ext_fmt, illegal: ext_ill};
    assign in_fire  = iValid & oReady;
    assign out_fire = oValid & iReady;
    assign oValid   = state != ST_EMPTY;
    // head always presents the oldest entry; skid only fills when head is stalled
    assign load_head = (state == ST_EMPTY) ? in_fire :
                       (state == ST_ONE)   ? in_fire & out_fire : out_fire;
    assign load_skid = (state == ST_ONE) & in_fire & ~out_fire;

    always_comb begin
        nxt = (state == ST_EMPTY) ? (in_fire ? ST_ONE : ST_EMPTY) :
              (state == ST_ONE)   ? ((in_fire & ~out_fire) ? ST_FULL :
                                     (~in_fire & out_fire) ? ST_EMPTY : ST_ONE) :
                                    (out_fire ? ST_ONE : ST_FULL);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= ST_EMPTY;
            oReady <= 1'b1;
            head   <= '0;
            skid   <= '0;
        end else begin
            state  <= nxt;
            oReady <= nxt != ST_FULL;
            if (load_head) head <= (state == ST_ONE || state == ST_EMPTY) ? new_e : skid;
            if (load_skid) skid <= new_e;
        end
    end

    assign oImm     = head.imm;
    assign oTarget  = head.target;
    assign oFmt     = head.fmt;
    assign oIllegal = head.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed bench with a queue-based reference model over three configurations.
module tb_imm_decode_stage;
    localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6;
    localparam int XL[3] = '{32, 64, 32};
    localparam bit ZI[3] = '{1'b1, 1'b1, 1'b0};
    localparam bit SH[3] = '{1'b1, 1'b1, 1'b0};

    localparam logic [31:0] BEQ    = 32'hFE000EE3;
    localparam logic [31:0] LUI    = 32'h80000537;
    localparam logic [31:0] SRAI   = 32'h4030D093;
    localparam logic [31:0] CSRRWI = 32'h3402D0F3;
    localparam logic [31:0] BAD    = 32'h0000007F;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, valid, ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic [31:0] imm_a, tgt_a, imm_c, tgt_c;
    logic [63:0] imm_b, tgt_b;
    logic [63:0] o_imm[3], o_tgt[3];
    logic [2:0]  o_fmt[3];
    logic        o_val[3], o_rdy[3], o_ill[3];

    exp_t q[3][$];
    bit   armed = 1'b0;
    int   checks = 0, failures = 0, nout = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) u32 (
        .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(o_rdy[0]), .iInstrucao(instr),
        .iPC(pc[31:0]), .oValid(o_val[0]), .iReady(ready), .oImm(imm_a), .oTarget(tgt_a),
        .oFmt(o_fmt[0]), .oIllegal(o_ill[0])
    );
    imm_decode_stage #(.XLEN(64)) u64 (
        .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(o_rdy[1]), .iInstrucao(instr),
        .iPC(pc), .oValid(o_val[1]), .iReady(ready), .oImm(imm_b), .oTarget(tgt_b),
        .oFmt(o_fmt[1]), .oIllegal(o_ill[1])
    );
    imm_decode_stage #(.XLEN(32), .EN_ZIMM(0), .EN_SHAMT(0)) u32n (
        .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(o_rdy[2]), .iInstrucao(instr),
        .iPC(pc[31:0]), .oValid(o_val[2]), .iReady(ready), .oImm(imm_c), .oTarget(tgt_c),
        .oFmt(o_fmt[2]), .oIllegal(o_ill[2])
    );

    assign o_imm[0] = {32'h0, imm_a};
    assign o_tgt[0] = {32'h0, tgt_a};
    assign o_imm[1] = imm_b;
    assign o_tgt[1] = tgt_b;
    assign o_imm[2] = {32'h0, imm_c};
    assign o_tgt[2] = {32'h0, tgt_c};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p,
                                   input int xlen, input bit zimm, input bit shamt);
        exp_t        e;
        logic [63:0] v, sum;
        logic [2:0]  f3;
        f3     = ins[14:12];
        v      = $signed(ins[31:20]);
        e.fmt  = F_I;
        e.ill  = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin v = $signed({ins[31:12], 12'h000}); e.fmt = F_U; end
            7'h6F: begin v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); e.fmt = F_J; end
            7'h63: begin v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); e.fmt = F_B; end
            7'h23: begin v = $signed({ins[31:25], ins[11:7]}); e.fmt = F_S; end
            7'h03, 7'h0F, 7'h1B, 7'h67: e.fmt = F_I;
            7'h13: begin
                if (shamt && (f3 == 3'b001 || f3 == 3'b101)) begin
                    if (xlen == 64) v = 64'(ins[25:20]);
                    else v = 64'(ins[24:20]);
                end
            end
            7'h73: begin
                if (zimm && f3[2]) begin v = 64'(ins[19:15]); e.fmt = F_Z; end
            end
            7'h33, 7'h3B: begin v = 64'h0; e.fmt = F_NONE; end
            default: begin v = 64'h0; e.fmt = F_NONE; e.ill = 1'b1; end
        endcase
        sum   = p + v;
        e.imm = (xlen == 64) ? v : {32'h0, v[31:0]};
        e.tgt = (xlen == 64) ? sum : {32'h0, sum[31:0]};
        return e;
    endfunction

    // Reference occupancy: a result is accepted while fewer than two are held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            armed = 1'b1;
        end else if (armed) begin
            for (int i = 0; i < 3; i++) begin
                bit inf, outf;
                inf  = valid && q[i].size() < 2;
                outf = ready && q[i].size() > 0;
                if (outf) void'(q[i].pop_front());
                if (inf) q[i].push_back(model(instr, pc, XL[i], ZI[i], SH[i]));
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("valid[%0d]", i), 64'(o_val[i]), 64'(q[i].size() > 0));
                chk($sformatf("ready[%0d]", i), 64'(o_rdy[i]), 64'(q[i].size() < 2));
                if (q[i].size() > 0) begin
                    chk($sformatf("imm[%0d]", i), o_imm[i], q[i][0].imm);
                    chk($sformatf("target[%0d]", i), o_tgt[i], q[i][0].tgt);
                    chk($sformatf("fmt[%0d]", i), 64'(o_fmt[i]), 64'(q[i][0].fmt));
                    chk($sformatf("illegal[%0d]", i), 64'(o_ill[i]), 64'(q[i][0].ill));
                end
            end
            if (o_val[0] && ready) nout++;
        end
    end

    task automatic step(input logic v, input logic r, input logic [31:0] ins, input logic [63:0] p);
        valid = v;
        ready = r;
        instr = ins;
        pc    = p;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] MIX[8] = '{32'h00001517, 32'hFF9FF0EF, 32'hFE112E23, 32'h00C58067,
                                       32'h00209093, 32'h00B50533, 32'hFFF2B503, 32'h0000000F};
    localparam bit MIX_RDY[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        exp_t e;
        int   n0;
        rst = 1'b1; valid = 1'b0; ready = 1'b0; instr = 32'h0; pc = 64'h0;

        e = model(BEQ, 64'h100, 32, 1'b1, 1'b1);
        chk("pin_beq_imm", e.imm, 64'hFFFFFFFC);
        chk("pin_beq_target", e.tgt, 64'h000000FC);
        chk("pin_beq_fmt", 64'(e.fmt), 64'(F_B));
        e = model(LUI, 64'h0, 64, 1'b1, 1'b1);
        chk("pin_lui_imm", e.imm, 64'hFFFFFFFF80000000);
        e = model(SRAI, 64'h0, 64, 1'b1, 1'b1);
        chk("pin_srai_imm", e.imm, 64'h3);
        e = model(CSRRWI, 64'h0, 32, 1'b1, 1'b1);
        chk("pin_csrrwi_imm", e.imm, 64'h5);
        e = model(BAD, 64'h0, 32, 1'b1, 1'b1);
        chk("pin_bad_ill", 64'(e.ill), 64'h1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_imm", o_imm[i], 64'h0);
            chk("rst_target", o_tgt[i], 64'h0);
            chk("rst_fmt", 64'(o_fmt[i]), 64'(F_NONE));
            chk("rst_illegal", 64'(o_ill[i]), 64'h0);
            chk("rst_valid", 64'(o_val[i]), 64'h0);
            chk("rst_ready", 64'(o_rdy[i]), 64'h1);
        end

        step(1'b1, 1'b1, BEQ, 64'h100);
        chk("beq_valid", 64'(o_val[0]), 64'h1);
        chk("beq_imm", o_imm[0], 64'hFFFFFFFC);
        chk("beq_target", o_tgt[0], 64'h000000FC);
        chk("beq_fmt", 64'(o_fmt[0]), 64'(F_B));
        step(1'b1, 1'b1, LUI, 64'h0);
        chk("lui64_imm", o_imm[1], 64'hFFFFFFFF80000000);
        chk("lui64_fmt", 64'(o_fmt[1]), 64'(F_U));
        step(1'b1, 1'b1, SRAI, 64'h0);
        chk("srai64_imm", o_imm[1], 64'h3);
        chk("srai_noshamt_imm", o_imm[2], 64'h403);
        step(1'b1, 1'b1, CSRRWI, 64'h0);
        chk("csrrwi_imm", o_imm[0], 64'h5);
        chk("csrrwi_fmt", 64'(o_fmt[0]), 64'(F_Z));
        chk("csrrwi_nozimm_imm", o_imm[2], 64'h340);
        chk("csrrwi_nozimm_fmt", 64'(o_fmt[2]), 64'(F_I));
        step(1'b1, 1'b1, BAD, 64'h0);
        chk("bad_imm", o_imm[0], 64'h0);
        chk("bad_illegal", 64'(o_ill[0]), 64'h1);
        chk("bad_fmt", 64'(o_fmt[0]), 64'(F_NONE));
        step(1'b1, 1'b1, 32'h00001517, 64'hFFFFFFFF_FFFFFFF0);
        chk("auipc_wrap32", o_tgt[0], 64'h00000FF0);
        chk("auipc_wrap64", o_tgt[1], 64'h0000000000000FF0);
        step(1'b0, 1'b1, 32'h0, 64'h0);

        step(1'b1, 1'b0, 32'h00100093, 64'h0);
        step(1'b1, 1'b0, 32'h00200093, 64'h4);
        chk("stall_ready_low", 64'(o_rdy[0]), 64'h0);
        step(1'b1, 1'b0, 32'h00300093, 64'h8);
        chk("stall_head", o_imm[0], 64'h1);
        step(1'b0, 1'b1, 32'h0, 64'h0);
        chk("drain_second", o_imm[0], 64'h2);
        step(1'b0, 1'b1, 32'h0, 64'h0);
        chk("drain_empty", 64'(o_val[0]), 64'h0);

        @(negedge clk);
        n0 = nout;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 32'h00000093 | (32'(k) << 20), 64'(k * 4));
        step(1'b0, 1'b1, 32'h0, 64'h0);
        chk("stream_count", 64'(nout - n0), 64'd10);
        chk("stream_done", 64'(o_val[0]), 64'h0);

        for (int k = 0; k < 12; k++) step(1'b1, MIX_RDY[k], MIX[k % 8], 64'h1000 + 64'(k * 4));
        step(1'b0, 1'b1, 32'h0, 64'h0);
        step(1'b0, 1'b1, 32'h0, 64'h0);

        step(1'b1, 1'b0, 32'h00500093, 64'h0);
        step(1'b1, 1'b0, 32'h00600093, 64'h0);
        chk("full_ready", 64'(o_rdy[1]), 64'h0);
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h00700093, 64'h0);
        rst = 1'b0;
        chk("flush_valid", 64'(o_val[1]), 64'h0);
        chk("flush_ready", 64'(o_rdy[1]), 64'h1);
        repeat (3) step(1'b0, 1'b1, 32'h0, 64'h0);
        chk("flush_gone", 64'(o_val[1]), 64'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
